reg_write_arbiter: RTL
======================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the single write port (We/Rw/WData) of the 8x16 register block between
//  NREQ writeback requesters (e.g. ALU result, memory load) using round-robin priority.
//  Drives the write port from registered outputs.
//  Keeps a per-register pending-write scoreboard so issue logic can stall on operands
//  whose writes are outstanding.
// PARAMETERS
//  NREQ  2   number of writeback requesters (2..4)
//  DW    16  data width, matches register block word
//  AW    3   register address width (2**AW registers, r0 hardwired zero)
// PORTS
//  Clock     in   1         system clock, all state updates on posedge
//  nReset    in   1         asynchronous, active-low reset
//  ReqValid  in   NREQ      requester i has a write pending
//  ReqAddr   in   NREQ*AW   dest register of requester i, slice [i*AW +: AW]
//  ReqData   in   NREQ*DW   write data of requester i, slice [i*DW +: DW]
//  ReqReady  out  NREQ      one-hot grant; handshake = ReqValid[i] & ReqReady[i] at posedge
//  We        out  1         register block write enable (registered)
//  Rw        out  AW        register block write address (registered)
//  WData     out  DW        register block write data (registered)
//  Reserve   in   1         issue logic claims dest register ResAddr
//  ResAddr   in   AW        register being reserved
//  Busy      out  2**AW     bit r set = write to r outstanding; Busy[0] always 0
// BEHAVIOUR
//  - Reset (nReset low, asynchronous): We=0, Rw=0, WData=0, Busy=0, ReqReady=0.
//    RR pointer=0, so requester 0 has highest priority.
//  - Grant is combinational from ReqValid and the RR pointer.
//    Scan starts at pointer and wraps modulo NREQ; the first valid requester gets ReqReady.
//    ReqReady is zero when no ReqValid is set. At most one ReqReady bit is high.
//  - No backpressure: a handshake occurs every cycle any requester is valid.
//  - On a handshake with requester g at posedge:
//    Rw<=ReqAddr[g], WData<=ReqData[g], We<=(ReqAddr[g]!=0).
//    Pointer <= (g+1) mod NREQ.
//  - No handshake: We<=0; Rw, WData and the pointer hold.
//  - Latency: register block commits the data on the posedge after the handshake.
//    The write is 1 cycle after acceptance. Throughput is 1 write/cycle.
//  - Writes to r0 complete the handshake but never assert We. Busy[0] is never set.
//  - Scoreboard updates at each posedge, in this order:
//    1. clear Busy[Rw] if We==1 (write committing this edge)
//    2. set Busy[ResAddr] if Reserve and ResAddr!=0
//    Reserve and commit to the same register on the same edge leaves the bit SET (new owner).
//  - Reserve of an already-busy register: bit stays set. There is no count; one outstanding
//    write per register is the issue logic's contract.
//  - A requester holding ReqValid with changing ReqAddr/ReqData between cycles is legal.
//    Only the values at the handshake edge are used.
//  - Reset asserted mid-operation: any registered write not yet committed is dropped (We->0).
//    Busy clears; requesters must re-present after reset.
// TESTING
//  1. Reset: hold nReset=0, toggle ReqValid -> We=0, Busy=0, ReqReady=0 throughout.
//  2. Single write: req0 valid, addr 5, data 16'hBEEF, 1 cycle -> ReqReady=01.
//     Next cycle We=1, Rw=5, WData=BEEF; regs[5]==BEEF after following edge.
//  3. Contention: both valid continuously, addr 1/2 -> grants alternate 01,10,01,10.
//     We high every cycle; Rw sequence 1,2,1,2.
//  4. r0 suppression: req1 addr 0, data FFFF -> ReqReady[1]=1 but We stays 0.
//     regs[0] reads 0 on both read ports.
//  5. Scoreboard: Reserve addr 3 -> Busy[3]=1. Write r3 -> Busy[3]=0 on the commit edge.
//     Reserve r3 on the commit edge -> Busy[3] stays 1. Reserve r0 -> Busy[0]=0.
//  6. Reset mid-op: handshake at edge k, nReset low before edge k+1.
//     Regs unchanged at k+1; Busy=0; pointer back to 0.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Writeback bus between the requesters/issue logic and the register write arbiter.
// Carries request handshakes, the registered register-file write port and the
// per-register pending-write scoreboard.
interface reg_write_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DW   = 16,
    parameter int AW   = 3
);
    logic [NREQ-1:0]    ReqValid;
    logic [NREQ*AW-1:0] ReqAddr;
    logic [NREQ*DW-1:0] ReqData;
    logic [NREQ-1:0]    ReqReady;

    logic               We;
    logic [AW-1:0]      Rw;
    logic [DW-1:0]      WData;

    logic               Reserve;
    logic [AW-1:0]      ResAddr;
    logic [2**AW-1:0]   Busy;

    // Requester / issue-logic side
    modport master (
        output ReqValid, ReqAddr, ReqData, Reserve, ResAddr,
        input  ReqReady, We, Rw, WData, Busy
    );

    // Arbiter side
    modport slave (
        input  ReqValid, ReqAddr, ReqData, Reserve, ResAddr,
        output ReqReady, We, Rw, WData, Busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NREQ
// writeback requesters. The write port is driven from flops, so a write commits
// one cycle after its handshake. A per-register scoreboard tracks reserved
// destinations until their write commits.
module reg_write_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                Clock,
    input  logic                nReset,
    reg_write_arbiter_if.slave  bus
);
    localparam int PW   = (NREQ > 2) ? 2 : 1;
    localparam int NREG = 2**AW;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   rw_q, rw_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [NREQ-1:0] gnt;
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;

    // Grant: scan from the pointer, wrapping, first valid requester wins.
    // Held at zero while reset is asserted so no handshake is advertised.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_vld && bus.ReqValid[idx] && nReset) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end

    // Next state of the write port, RR pointer and scoreboard.
    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        if (gnt_vld) begin
            rw_d    = bus.ReqAddr[gnt_idx*AW +: AW];
            wdata_d = bus.ReqData[gnt_idx*DW +: DW];
            // r0 is hardwired zero: the handshake completes but nothing is written.
            we_d    = (rw_d != '0);
            ptr_d   = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
        end

        // Commit clears first, then a reservation sets: a same-edge reserve
        // of the committing register belongs to the new owner and stays set.
        busy_d = busy_q;
        if (we_q) busy_d[rw_q] = 1'b0;
        if (bus.Reserve && (bus.ResAddr != '0)) busy_d[bus.ResAddr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any write not yet committed.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            rw_q    <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ReqReady = gnt;
    assign bus.We       = we_q;
    assign bus.Rw       = rw_q;
    assign bus.WData    = wdata_q;
    assign bus.Busy     = busy_q;
endmodule
